// File: rtl/itrx_amba4_apb_mst.sv
// APB4 requester: one command in, one APB transfer, one response out.
// Optional ACCESS abort timer is compiled in with ITRX_APB_MST_TIMEOUT_EN.
package itrx_amba4_apb_pkg;
    typedef enum logic {READ = 1'b0, WRITE = 1'b1} te_pwrite;
    typedef struct packed {
        logic pprot2;
        logic pprot1;
        logic pprot0;
    } ts_pprot;
endpackage

module itrx_amba4_apb_mst
    import itrx_amba4_apb_pkg::*;
#(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int TO_CYC = 256
) (
    input  logic            clk,
    input  logic            rst,
    // Valid/ready: a beat moves on a rising edge where valid and ready are both 1;
    // the source holds its valid and payload steady until that edge.
    input  logic            req_vld,
    output logic            req_rdy,
    input  logic            req_write,
    input  logic [AW-1:0]   req_addr,
    input  logic [DW-1:0]   req_wdata,
    input  logic [DW/8-1:0] req_strb,
    input  logic [2:0]      req_prot,
    output logic            rsp_vld,
    input  logic            rsp_rdy,
    output logic [DW-1:0]   rsp_rdata,
    output logic            rsp_err,
    output logic            rsp_to,
    output logic            psel,
    output logic            penable,
    output logic            pwrite,
    output logic [AW-1:0]   paddr,
    output logic [DW-1:0]   pwdata,
    output logic [DW/8-1:0] pstrb,
    output logic [2:0]      pprot,
    input  logic [DW-1:0]   prdata,
    input  logic            pready,
    input  logic            pslverr,
    output logic [1:0]      dbg_state
);

    if (!(DW == 8 || DW == 16 || DW == 32)) begin : g_bad_dw
        $error("itrx_amba4_apb_mst: DW must be 8, 16 or 32");
    end
    if (TO_CYC < 1) begin : g_bad_to
        $error("itrx_amba4_apb_mst: TO_CYC must be at least 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } te_state;

    te_state            r_state;
    logic               r_req_rdy;
    logic               r_rsp_vld;
    logic [DW-1:0]      r_rsp_rdata;
    logic               r_rsp_err;
    logic               r_psel;
    logic               r_penable;
    te_pwrite           r_pwrite;
    logic [AW-1:0]      r_paddr;
    logic [DW-1:0]      r_pwdata;
    logic [DW/8-1:0]    r_pstrb;
    ts_pprot            r_pprot;

`ifdef ITRX_APB_MST_TIMEOUT_EN
    localparam int CW = $clog2(TO_CYC + 1);
    logic [CW-1:0]      r_to_cnt;
    logic               r_rsp_to;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_req_rdy   <= 1'b1;
            r_rsp_vld   <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= READ;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_pstrb     <= '0;
            r_pprot     <= '0;
`ifdef ITRX_APB_MST_TIMEOUT_EN
            r_to_cnt    <= '0;
            r_rsp_to    <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_vld && r_req_rdy) begin
                        // Request fields are captured once and stay put until the next command.
                        r_pwrite  <= te_pwrite'(req_write);
                        r_paddr   <= req_addr;
                        r_pwdata  <= req_wdata;
                        r_pstrb   <= req_write ? req_strb : '0;
                        r_pprot   <= ts_pprot'(req_prot);
                        r_psel    <= 1'b1;
                        r_req_rdy <= 1'b0;
`ifdef ITRX_APB_MST_TIMEOUT_EN
                        r_to_cnt  <= '0;
`endif
                        r_state   <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (pready) begin
                        r_rsp_rdata <= (r_pwrite == READ && !pslverr) ? prdata : '0;
                        r_rsp_err   <= pslverr;
`ifdef ITRX_APB_MST_TIMEOUT_EN
                        r_rsp_to    <= 1'b0;
`endif
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_rsp_vld   <= 1'b1;
                        r_state     <= ST_RESP;
                    end
`ifdef ITRX_APB_MST_TIMEOUT_EN
                    // A completer answering on the limit cycle still wins over the abort.
                    else if (r_to_cnt == CW'(TO_CYC)) begin
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= 1'b1;
                        r_rsp_to    <= 1'b1;
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_rsp_vld   <= 1'b1;
                        r_state     <= ST_RESP;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
`endif
                end
                ST_RESP: begin
                    if (rsp_rdy) begin
                        r_rsp_vld <= 1'b0;
                        r_req_rdy <= 1'b1;
                        r_state   <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_rdy   = r_req_rdy;
    assign rsp_vld   = r_rsp_vld;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign psel      = r_psel;
    assign penable   = r_penable;
    assign pwrite    = r_pwrite;
    assign paddr     = r_paddr;
    assign pwdata    = r_pwdata;
    assign pstrb     = r_pstrb;
    assign pprot     = r_pprot;
    assign dbg_state = r_state;

`ifdef ITRX_APB_MST_TIMEOUT_EN
    assign rsp_to    = r_rsp_to;
`else
    assign rsp_to    = 1'b0;
`endif

endmodule
